fsmc_sync_bridge: RTL

Parametrised successor to the FSMC synchronous slave interface. Samples asynchronous FSMC bus pins into the clk domain through a configurable synchroniser and decodes write and read strobes. It drives a backend RAM/register port with byte enables, a variable-latency read handshake and a read timeout, and optionally demultiplexes address and data (NADV) mode. Sits between the MCU FSMC pins and the FPGA register file or RAM.

---
 rtl/fsmc_pkg.sv | 18 +
 rtl/fsmc_pin_sync.sv | 30 +++
 rtl/fsmc_sync_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fsmc_pkg.sv
// rtl/fsmc_pkg.sv - shared types and constants for the FSMC synchronous bridge
package fsmc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_HOLD = 2'd2
    } fsmc_state_t;

    // Synchroniser reset levels: active-low pins come out of reset deasserted
    localparam logic       PIN_INACTIVE  = 1'b1;
    localparam logic [3:0] STRB_INACTIVE = {4{PIN_INACTIVE}};

    function automatic int tmo_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fsmc_pin_sync.sv
// rtl/fsmc_pin_sync.sv - parametrised flop chain for sampling and aligning bus pins
module fsmc_pin_sync #(
    parameter int                 p_WIDTH   = 1,
    parameter int                 p_STAGES  = 2,
    parameter logic [p_WIDTH-1:0] p_RST_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [p_WIDTH-1:0] d,
    output logic [p_WIDTH-1:0] q
);

    logic [p_WIDTH-1:0] stage_q [p_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < p_STAGES; i++) begin
                stage_q[i] <= p_RST_VAL;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < p_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[p_STAGES-1];

endmodule

// File: rtl/fsmc_sync_bridge.sv
// rtl/fsmc_sync_bridge.sv - FSMC pin synchroniser and strobe decoder driving a backend RAM port
module fsmc_sync_bridge
    import fsmc_pkg::*;
#(
    parameter int p_WIDTH_ADDR  = 8,
    parameter int p_WIDTH_DATA  = 16,
    parameter int p_SYNC_STAGES = 2,
    parameter int p_MUX_MODE    = 0,
    parameter int p_RD_TIMEOUT  = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [p_WIDTH_ADDR-1:0]   fsmc_A,
    input  logic [p_WIDTH_DATA-1:0]   fsmc_wdata,
    output logic [p_WIDTH_DATA-1:0]   fsmc_rdata,
    output logic                      fsmc_rdata_oe,
    input  logic                      fsmc_NE,
    input  logic                      fsmc_NWE,
    input  logic                      fsmc_NOE,
    input  logic [p_WIDTH_DATA/8-1:0] fsmc_NBL,
    input  logic                      fsmc_NADV,
    output logic [p_WIDTH_ADDR-1:0]   addr,
    output logic [p_WIDTH_DATA-1:0]   wdata,
    output logic [p_WIDTH_DATA/8-1:0] wbe,
    output logic                      wen,
    output logic                      ren,
    input  logic [p_WIDTH_DATA-1:0]   rdata,
    input  logic                      rvalid,
    output logic                      busy,
    output logic                      rd_timeout,
    output logic                      proto_err,
    input  logic                      err_clr
);

    localparam int NB     = p_WIDTH_DATA / 8;
    localparam int DATA_W = NB + p_WIDTH_ADDR + p_WIDTH_DATA;
    localparam int CW     = tmo_cnt_width(p_RD_TIMEOUT);
    localparam logic [CW-1:0]     TMO_LAST  = CW'(p_RD_TIMEOUT);
    localparam logic [2:0]        WARM_DONE = 3'(p_SYNC_STAGES);
    localparam logic [DATA_W-1:0] DATA_RST  = {{NB{PIN_INACTIVE}}, {(p_WIDTH_ADDR + p_WIDTH_DATA){1'b0}}};

    logic [3:0]              strb_s;
    logic [DATA_W-1:0]       data_s;
    logic                    ne_s, nwe_s, noe_s, nadv_s;
    logic [NB-1:0]           nbl_s;
    logic [p_WIDTH_ADDR-1:0] a_s;
    logic [p_WIDTH_DATA-1:0] wd_s;

    fsmc_pin_sync #(
        .p_WIDTH   (4),
        .p_STAGES  (p_SYNC_STAGES),
        .p_RST_VAL (STRB_INACTIVE)
    ) u_sync_strb (
        .clk (clk),
        .rst (rst),
        .d   ({fsmc_NE, fsmc_NWE, fsmc_NOE, fsmc_NADV}),
        .q   (strb_s)
    );

    fsmc_pin_sync #(
        .p_WIDTH   (DATA_W),
        .p_STAGES  (p_SYNC_STAGES),
        .p_RST_VAL (DATA_RST)
    ) u_sync_data (
        .clk (clk),
        .rst (rst),
        .d   ({fsmc_NBL, fsmc_A, fsmc_wdata}),
        .q   (data_s)
    );

    assign {ne_s, nwe_s, noe_s, nadv_s} = strb_s;
    assign {nbl_s, a_s, wd_s}           = data_s;

    logic s_wr, s_rd, s_wr_q, s_rd_q;
    logic wr_fall, rd_rise;
    logic [2:0] warm;
    logic armed;

    assign s_wr = !ne_s &  noe_s & !nwe_s;
    assign s_rd = !ne_s & !noe_s &  nwe_s;

    // Edges only count once the chain has refilled after reset and the bus was seen idle
    assign wr_fall = armed & s_wr_q & !s_wr;
    assign rd_rise = armed & s_rd & !s_rd_q;

    logic                    addr_load;
    logic [p_WIDTH_ADDR-1:0] addr_src;
    logic                    unused_pins;

    generate
        if (p_MUX_MODE != 0) begin : g_mux
            assign addr_load   = !ne_s & !nadv_s;
            assign addr_src    = wd_s[p_WIDTH_ADDR-1:0];
            assign unused_pins = ^a_s;
        end else begin : g_sep
            assign addr_load   = s_wr | s_rd;
            assign addr_src    = a_s;
            assign unused_pins = nadv_s;
        end
    endgenerate

    fsmc_state_t             state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx, cnt_inc;
    logic                    wen_nx, ren_nx, rdata_load, tmo_set, proto_set;
    logic [p_WIDTH_DATA-1:0] rdata_src;

    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        wen_nx     = 1'b0;
        ren_nx     = 1'b0;
        rdata_load = 1'b0;
        rdata_src  = rdata;
        tmo_set    = 1'b0;
        proto_set  = 1'b0;
        case (state)
            IDLE: begin
                wen_nx = wr_fall;
                if (rd_rise) begin
                    ren_nx   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = RD_WAIT;
                end
            end
            RD_WAIT: begin
                proto_set = wr_fall | rd_rise;
                // Data arriving on the last permitted cycle still beats the timeout
                if (rvalid) begin
                    rdata_load = 1'b1;
                    state_nx   = RD_HOLD;
                end else if (cnt_inc == TMO_LAST) begin
                    rdata_load = 1'b1;
                    rdata_src  = '1;
                    tmo_set    = 1'b1;
                    state_nx   = RD_HOLD;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            RD_HOLD: begin
                proto_set = wr_fall | rd_rise;
                if (!s_rd) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_wr_q     <= 1'b0;
            s_rd_q     <= 1'b0;
            warm       <= '0;
            armed      <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            wbe        <= '0;
            wen        <= 1'b0;
            ren        <= 1'b0;
            fsmc_rdata <= '0;
            rd_timeout <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            s_wr_q <= s_wr;
            s_rd_q <= s_rd;
            if (warm != WARM_DONE) begin
                warm <= warm + 3'd1;
            end
            if (warm == WARM_DONE && !s_wr && !s_rd) begin
                armed <= 1'b1;
            end
            if (addr_load) begin
                addr <= addr_src;
            end
            if (s_wr) begin
                wdata <= wd_s;
                wbe   <= ~nbl_s;
            end
            wen <= wen_nx;
            ren <= ren_nx;
            if (rdata_load) begin
                fsmc_rdata <= rdata_src;
            end
            if (tmo_set) begin
                rd_timeout <= 1'b1;
            end else if (err_clr) begin
                rd_timeout <= 1'b0;
            end
            if (proto_set) begin
                proto_err <= 1'b1;
            end else if (err_clr) begin
                proto_err <= 1'b0;
            end
        end
    end

    assign busy          = (state != IDLE);
    assign fsmc_rdata_oe = !fsmc_NE & !fsmc_NOE;

endmodule
